// File: rtl/sccb_target_if.sv
// Bus bundle for the receive-only SCCB target: the two SCCB pins, the decoded
// write/error outputs and the fabric read port into the mirrored register file.
interface sccb_target_if;
  logic       sioc;
  logic       siod;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] last_addr;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       swrst;
  logic       err_id;
  logic       err_frame;
  logic       busy;
  logic [2:0] dbg_state;

  modport master (
    output sioc, siod, rd_addr,
    input  wr_valid, wr_addr, wr_data, last_addr, rd_data,
    input  swrst, err_id, err_frame, busy, dbg_state
  );

  modport slave (
    input  sioc, siod, rd_addr,
    output wr_valid, wr_addr, wr_data, last_addr, rd_data,
    output swrst, err_id, err_frame, busy, dbg_state
  );
endinterface

// File: rtl/sccb_target.sv
// Receive-only SCCB target: decodes ID/ADDR/DATA write frames from the
// synchronized pins and mirrors them into a 256x8 register file.
module sccb_target #(
  parameter logic [6:0] DEV_ID      = 7'h21,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] SWRST_ADDR  = 8'h12
) (
  input logic         clk,
  input logic         rst_n,
  sccb_target_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ID, S_ADDR, S_DATA, S_WAIT} state_t;

  logic [SYNC_STAGES-1:0] c_sync, d_sync;
  logic c_q, d_q, c_s, d_s;
  logic start_ev, stop_ev, bit_ev, fall_ev;

  state_t     state, state_n;
  logic [3:0] bitcnt, bitcnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] addr_q, addr_n;
  logic [7:0] last_q, last_n;
  logic       wf_done, wf_n;
  logic       pend, pend_n;
  logic       xbit, xbit_n;
  logic       at_bound, commit, id_err, fr_err, swrst_fire;

  logic       wr_valid_q, swrst_q, err_id_q, err_frame_q;
  logic [7:0] wr_addr_q, wr_data_q, rd_data_q;
  logic [7:0] regs [256];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync <= '0;
      d_sync <= '0;
      c_q    <= 1'b0;
      d_q    <= 1'b0;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], bus.sioc};
      d_sync <= {d_sync[SYNC_STAGES-2:0], bus.siod};
      c_q    <= c_s;
      d_q    <= d_s;
    end
  end

  assign c_s      = c_sync[SYNC_STAGES-1];
  assign d_s      = d_sync[SYNC_STAGES-1];
  assign start_ev = c_q & c_s & d_q & ~d_s;
  assign stop_ev  = c_q & c_s & ~d_q & d_s;
  assign bit_ev   = ~c_q & c_s;
  assign fall_ev  = c_q & ~c_s;

  // The sioc rise that precedes a STOP looks like a bit. pend marks a bit not yet
  // confirmed by a sioc fall, so STOP classification can discount it.
  assign at_bound = (bitcnt == 4'd0) || (pend && (bitcnt == 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bitcnt  <= '0;
      shift   <= '0;
      addr_q  <= '0;
      last_q  <= '0;
      wf_done <= 1'b0;
      pend    <= 1'b0;
      xbit    <= 1'b0;
    end else begin
      state   <= state_n;
      bitcnt  <= bitcnt_n;
      shift   <= shift_n;
      addr_q  <= addr_n;
      last_q  <= last_n;
      wf_done <= wf_n;
      pend    <= pend_n;
      xbit    <= xbit_n;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    addr_n   = addr_q;
    last_n   = last_q;
    wf_n     = wf_done;
    pend_n   = pend;
    xbit_n   = xbit;
    commit   = 1'b0;
    id_err   = 1'b0;
    fr_err   = 1'b0;
    if (start_ev) begin
      state_n  = S_ID;
      bitcnt_n = '0;
      shift_n  = '0;
      wf_n     = 1'b0;
      pend_n   = 1'b0;
      xbit_n   = 1'b0;
    end else if (stop_ev) begin
      state_n = S_IDLE;
      pend_n  = 1'b0;
      xbit_n  = 1'b0;
      if (state == S_ID || state == S_ADDR) begin
        if (!at_bound) fr_err = 1'b1;
      end else if (state == S_DATA) begin
        // Address complete and no data bits: a 2-phase sub-address set.
        if (at_bound) last_n = addr_q;
        else          fr_err = 1'b1;
      end
    end else if (bit_ev) begin
      if (state == S_WAIT) begin
        xbit_n = 1'b1;
      end else if (state != S_IDLE) begin
        pend_n = 1'b1;
        if (bitcnt == 4'd8) begin
          bitcnt_n = '0;
          shift_n  = '0;
          if (state == S_ID) begin
            if (shift[7:1] == DEV_ID && !shift[0]) begin
              state_n = S_ADDR;
            end else begin
              id_err  = 1'b1;
              state_n = S_WAIT;
            end
          end else if (state == S_ADDR) begin
            addr_n  = shift;
            state_n = S_DATA;
          end else begin
            commit  = 1'b1;
            state_n = S_WAIT;
          end
        end else begin
          bitcnt_n = bitcnt + 4'd1;
          shift_n  = {shift[6:0], d_s};
        end
      end
    end else if (fall_ev) begin
      pend_n = 1'b0;
      xbit_n = 1'b0;
      // A completed extra bit after the frame is flagged once per frame.
      if (xbit && !wf_done) begin
        fr_err = 1'b1;
        wf_n   = 1'b1;
      end
    end
  end

  assign swrst_fire = wr_valid_q && (wr_addr_q == SWRST_ADDR) && wr_data_q[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      swrst_q     <= 1'b0;
      err_id_q    <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      wr_valid_q  <= commit;
      swrst_q     <= swrst_fire;
      err_id_q    <= id_err;
      err_frame_q <= fr_err;
      if (commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= shift;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) regs[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (swrst_fire) begin
        for (int i = 0; i < 256; i++) regs[i] <= '0;
      end else if (commit) begin
        regs[addr_q] <= shift;
      end
      rd_data_q <= regs[bus.rd_addr];
    end
  end

  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.last_addr = last_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.swrst     = swrst_q;
  assign bus.err_id    = err_id_q;
  assign bus.err_frame = err_frame_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB frames, a frame-level reference model
// that predicts output pulses into a queue, and a monitor that pops them.
module tb_sccb_target;
  localparam int Q = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sccb_target_if bus();

  sccb_target #(.DEV_ID(7'h21), .SYNC_STAGES(2), .SWRST_ADDR(8'h12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise27_cyc = 0;
  int last_wr_cyc = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  mregs[256];
  logic [7:0]  exp_last;
  logic [7:0]  prev_last;
  logic [15:0] init_tab[35];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input logic [19:0] act, input string name);
    logic [19:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event %05h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        errors++;
        $display("FAIL %s: got event %05h expected %05h", name, act, e);
      end
    end
  endtask

  // Monitor: every output pulse must match the next predicted event.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 8'h00;
    end else begin
      if (bus.wr_valid) begin
        last_wr_cyc = cyc;
        check("wr_latency", 32'(cyc - rise27_cyc), 32'd3);
        pop_cmp({4'd1, bus.wr_addr, bus.wr_data}, "wr");
      end
      if (bus.swrst) begin
        check("swrst_timing", 32'(cyc - last_wr_cyc), 32'd1);
        pop_cmp({4'd2, 16'h0000}, "swrst");
      end
      if (bus.err_id)    pop_cmp({4'd3, 16'h0000}, "err_id");
      if (bus.err_frame) pop_cmp({4'd4, 16'h0000}, "err_frame");
      if (bus.last_addr != prev_last) begin
        pop_cmp({4'd5, bus.last_addr, 8'h00}, "last_addr");
        prev_last = bus.last_addr;
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
  endtask

  // Frame-level model: outcome depends only on the ID byte and how many bits were sent.
  task automatic predict(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int nbits, input int rst_at);
    logic id_ok;
    id_ok = (b0 == 8'h42);
    if (rst_at >= 0) return;
    if (nbits < 9) begin
      if (nbits != 0) exp_q.push_back({4'd4, 16'h0000});
    end else if (!id_ok) begin
      exp_q.push_back({4'd3, 16'h0000});
      if (nbits > 9) exp_q.push_back({4'd4, 16'h0000});
    end else if (nbits == 9) begin
      // ID-only frame: nothing to report
    end else if (nbits < 18) begin
      exp_q.push_back({4'd4, 16'h0000});
    end else if (nbits == 18) begin
      if (b1 != exp_last) exp_q.push_back({4'd5, b1, 8'h00});
      exp_last = b1;
    end else if (nbits < 27) begin
      exp_q.push_back({4'd4, 16'h0000});
    end else begin
      exp_q.push_back({4'd1, b1, b2});
      mregs[b1] = b2;
      if (b1 == 8'h12 && b2[7]) begin
        exp_q.push_back({4'd2, 16'h0000});
        clear_model();
      end
      if (nbits > 27) exp_q.push_back({4'd4, 16'h0000});
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic do_start();
    bus.siod = 1'b1; wait_q();
    bus.sioc = 1'b1; wait_q();
    bus.siod = 1'b0; wait_q();
    bus.sioc = 1'b0; wait_q();
  endtask

  task automatic do_stop();
    bus.siod = 1'b0; wait_q();
    bus.sioc = 1'b1; wait_q();
    bus.siod = 1'b1; wait_q();
    repeat (5) wait_q();
  endtask

  task automatic send_bit(input logic v, input int idx);
    bus.siod = v; wait_q();
    bus.sioc = 1'b1;
    if (idx == 26) rise27_cyc = cyc;
    wait_q(); wait_q();
    bus.sioc = 1'b0; wait_q();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {9'd0, bus.wr_valid, bus.wr_addr, bus.wr_data, bus.swrst, bus.err_id, bus.err_frame, bus.busy},
          32'd0);
    check("reset_last_rd", {16'd0, bus.last_addr, bus.rd_data}, 32'd0);
    rst_n = 1'b1;
    clear_model();
    exp_last = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int nbits, input int rst_at);
    logic [26:0] stream;
    logic        v;
    stream = {b0, 1'($urandom_range(0, 1)), b1, 1'($urandom_range(0, 1)),
              b2, 1'($urandom_range(0, 1))};
    predict(b0, b1, b2, nbits, rst_at);
    do_start();
    check("busy_in_frame", 32'(bus.busy), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) pulse_reset();
      v = (i < 27) ? stream[26 - i] : 1'($urandom_range(0, 1));
      send_bit(v, i);
    end
    do_stop();
    check("busy_after_stop", 32'(bus.busy), 32'd0);
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string name);
    bus.rd_addr = a;
    repeat (2) @(negedge clk);
    check(name, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb_tab[9];
    logic [7:0] b0, b1, b2, ra;
    nb_tab = '{5, 9, 15, 18, 22, 27, 27, 27, 30};
    init_tab = '{16'h1280, 16'h1101, 16'h3A04, 16'h1200, 16'h8C00, 16'h0400, 16'h40D0,
                 16'h1448, 16'h4FB3, 16'h50B3, 16'h5100, 16'h523D, 16'h53A7, 16'h54E4,
                 16'h589E, 16'h3DC0, 16'h1714, 16'h1802, 16'h3280, 16'h1903, 16'h1A7B,
                 16'h030A, 16'h0C00, 16'h3E00, 16'h703A, 16'h7135, 16'h7211, 16'h73F0,
                 16'hA202, 16'h7A20, 16'h7B10, 16'h7C1E, 16'h7D35, 16'h7E5A, 16'hB084};
    clear_model();
    exp_last  = 8'h00;
    prev_last = 8'h00;
    bus.sioc = 1'b1;
    bus.siod = 1'b1;
    bus.rd_addr = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("por_outputs",
          {9'd0, bus.wr_valid, bus.wr_addr, bus.wr_data, bus.swrst, bus.err_id, bus.err_frame, bus.busy},
          32'd0);
    check("por_last_rd", {16'd0, bus.last_addr, bus.rd_data}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'h42, 8'h40, 8'hF0, 27, -1);
    rd_chk(8'h40, 8'hF0, "rd_single_write");

    send_frame(8'h44, 8'h41, 8'hAA, 27, -1);
    send_frame(8'h43, 8'h41, 8'hAA, 27, -1);
    rd_chk(8'h41, 8'h00, "rd_after_bad_id");

    send_frame(8'h42, 8'h55, 8'h66, 15, -1);
    rd_chk(8'h55, 8'h00, "rd_after_trunc");
    send_frame(8'h42, 8'h3A, 8'h00, 18, -1);
    check("last_addr_2phase", 32'(bus.last_addr), 32'h3A);

    send_frame(8'h42, 8'h40, 8'h55, 27, -1);
    rd_chk(8'h40, 8'h55, "rd_before_swrst");
    send_frame(8'h42, 8'h12, 8'h80, 27, -1);
    rd_chk(8'h40, 8'h00, "rd_40_after_swrst");
    rd_chk(8'h12, 8'h00, "rd_12_after_swrst");

    send_frame(8'h42, 8'h20, 8'h77, 27, -1);
    for (int i = 0; i < 35; i++) send_frame(8'h42, init_tab[i][15:8], init_tab[i][7:0], 27, -1);
    rd_chk(8'hB0, 8'h84, "init_B0");
    rd_chk(8'h3D, 8'hC0, "init_3D");
    rd_chk(8'h40, 8'hD0, "init_40");
    rd_chk(8'h20, 8'h00, "init_pre_clear");

    send_frame(8'h42, 8'h33, 8'h99, 27, 22);
    rd_chk(8'h33, 8'h00, "rd_after_abort");
    rd_chk(8'hB0, 8'h00, "rd_cleared_by_reset");
    send_frame(8'h42, 8'h11, 8'h00, 27, -1);
    rd_chk(8'h11, 8'h00, "rd_after_recover");

    for (int n = 0; n < 25; n++) begin
      b0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h42;
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      send_frame(b0, b1, b2, nb_tab[$urandom_range(0, 8)], -1);
      rd_chk(b1, mregs[b1], "rand_rd_target");
      ra = 8'($urandom_range(0, 255));
      rd_chk(ra, mregs[ra], "rand_rd_any");
    end

    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
